// File: rtl/qspi_slave_mode_dec.sv
// qspi_slave_mode_dec
//   Watches the first byte (opcode) of every QSPI frame and tracks the device's
//   bus-width mode (QPI / SPI / DPI). The opcode is shifted in at the width of
//   the mode latched at frame start. A mode change is committed only when
//   chip select returns high after a frame that carried the opcode alone.
//
//   Optional DPI support is compiled in when macro QSPI_SLAVE_DPI_EN is
//   defined. Without it, the DPI state and the 2-bit shift path do not exist.
//
// Ports
//   clock        system clock. All logic runs on its rising edge.
//   reset        asynchronous, active-high reset.
//   io_cs_n      chip select, active low. Already synchronised to clock.
//   io_sck       serial clock. Already synchronised to clock.
//   io_dq[3:0]   data lines. Already synchronised to clock.
//   io_inst      last complete opcode byte.
//   io_inst_vld  one-cycle pulse when io_inst is updated.
//   io_spi_mode  mode code bit 0.
//   io_dpi_mode  mode code bit 1. The mode code is QPI=00, SPI=01, DPI=10.
//   io_mode_chg  one-cycle pulse coincident with a mode register update.
module qspi_slave_mode_dec #(
  parameter logic [7:0] QPIEN_OP = 8'h35,
  parameter logic [7:0] QPIDI_OP = 8'hF5,
  parameter logic [7:0] DPIEN_OP = 8'h37,
  parameter logic [7:0] DPIDI_OP = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_cs_n,
  input  logic       io_sck,
  input  logic [3:0] io_dq,
  output logic [7:0] io_inst,
  output logic       io_inst_vld,
  output logic       io_spi_mode,
  output logic       io_dpi_mode,
  output logic       io_mode_chg
);

  typedef enum logic [1:0] {
    MODE_QPI = 2'b00,
    MODE_SPI = 2'b01,
    MODE_DPI = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    INST = 2'b01,
    REST = 2'b10
  } frame_t;

  frame_t     state, state_next;
  mode_t      mode_q, mode_next, frame_mode;
  logic [7:0] shift_q, shift_in;
  logic [3:0] bit_cnt, step;
  logic       sck_prev, cs_prev, ext_q;
  logic       sck_edge, byte_done;

  assign io_spi_mode = mode_q[0];
  assign io_dpi_mode = mode_q[1];

  // Shift path selected by the mode captured at frame start.
  always_comb begin
    shift_in = {shift_q[6:0], io_dq[0]};
    step     = 4'd1;
    case (frame_mode)
      MODE_QPI: begin
        shift_in = {shift_q[3:0], io_dq};
        step     = 4'd4;
      end
`ifdef QSPI_SLAVE_DPI_EN
      MODE_DPI: begin
        shift_in = {shift_q[5:0], io_dq[1:0]};
        step     = 4'd2;
      end
`endif
      default: begin
        shift_in = {shift_q[6:0], io_dq[0]};
        step     = 4'd1;
      end
    endcase
  end

  always_comb begin
    sck_edge  = io_sck & ~sck_prev & ~io_cs_n;
    byte_done = sck_edge && (state == INST) && ((bit_cnt + step) == 4'd8);

    state_next = state;
    case (state)
      // A frame starts only on a real high-to-low transition of cs_n. cs_prev
      // resets low, so a frame already in progress at reset release is skipped.
      IDLE: if (!io_cs_n && cs_prev) state_next = INST;
      INST: begin
        if (io_cs_n)        state_next = IDLE;
        else if (byte_done) state_next = REST;
      end
      REST: if (io_cs_n) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    mode_next = mode_q;
    if ((state == REST) && io_cs_n && !ext_q) begin
      if ((io_inst == QPIEN_OP) && ((mode_q == MODE_SPI) || (mode_q == MODE_DPI)))
        mode_next = MODE_QPI;
      else if ((io_inst == QPIDI_OP) && (mode_q == MODE_QPI))
        mode_next = MODE_SPI;
`ifdef QSPI_SLAVE_DPI_EN
      else if ((io_inst == DPIEN_OP) && (mode_q == MODE_SPI))
        mode_next = MODE_DPI;
      else if ((io_inst == DPIDI_OP) && (mode_q == MODE_DPI))
        mode_next = MODE_SPI;
`endif
    end
  end

`ifndef QSPI_SLAVE_DPI_EN
  // The DPI opcodes have no effect in this build.
  logic unused_dpi_ops;
  assign unused_dpi_ops = ^{DPIEN_OP, DPIDI_OP};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= MODE_SPI;
      frame_mode  <= MODE_SPI;
      shift_q     <= '0;
      bit_cnt     <= '0;
      sck_prev    <= 1'b0;
      cs_prev     <= 1'b0;
      ext_q       <= 1'b0;
      io_inst     <= '0;
      io_inst_vld <= 1'b0;
      io_mode_chg <= 1'b0;
    end else begin
      sck_prev    <= io_sck;
      cs_prev     <= io_cs_n;
      state       <= state_next;
      mode_q      <= mode_next;
      io_mode_chg <= (mode_next != mode_q);
      io_inst_vld <= 1'b0;
      if ((state == IDLE) && (state_next == INST)) begin
        bit_cnt    <= '0;
        shift_q    <= '0;
        ext_q      <= 1'b0;
        frame_mode <= mode_q;
      end else if ((state == INST) && sck_edge) begin
        shift_q <= shift_in;
        bit_cnt <= bit_cnt + step;
        if (byte_done) begin
          io_inst     <= shift_in;
          io_inst_vld <= 1'b1;
        end
      end else if ((state == REST) && sck_edge) begin
        ext_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qspi_slave_mode_dec.sv
module tb_qspi_slave_mode_dec;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_cs_n;
  logic       io_sck;
  logic [3:0] io_dq;
  logic [7:0] io_inst;
  logic       io_inst_vld;
  logic       io_spi_mode;
  logic       io_dpi_mode;
  logic       io_mode_chg;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_inst_q[$];
  logic [1:0] exp_mode_q[$];
  logic [1:0] mdl_mode;
  logic [7:0] mdl_inst;

  always #5 clock = ~clock;

  qspi_slave_mode_dec #(
    .QPIEN_OP(8'h35),
    .QPIDI_OP(8'hF5),
    .DPIEN_OP(8'h37),
    .DPIDI_OP(8'hFF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .io_cs_n    (io_cs_n),
    .io_sck     (io_sck),
    .io_dq      (io_dq),
    .io_inst    (io_inst),
    .io_inst_vld(io_inst_vld),
    .io_spi_mode(io_spi_mode),
    .io_dpi_mode(io_dpi_mode),
    .io_mode_chg(io_mode_chg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_next(input logic [1:0] m, input logic [7:0] op);
    if (op == 8'h35 && (m == 2'b01 || m == 2'b10)) return 2'b00;
    if (op == 8'hF5 && m == 2'b00) return 2'b01;
`ifdef QSPI_SLAVE_DPI_EN
    if (op == 8'h37 && m == 2'b01) return 2'b10;
    if (op == 8'hFF && m == 2'b10) return 2'b01;
`endif
    return m;
  endfunction

  // Scoreboard side: every output pulse must match a queued expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (io_inst_vld) begin
        if (exp_inst_q.size() == 0) check("vld_unexpected", {31'd0, io_inst_vld}, 32'd0);
        else check("inst_on_vld", {24'd0, io_inst}, {24'd0, exp_inst_q.pop_front()});
      end
      if (io_mode_chg) begin
        if (exp_mode_q.size() == 0) check("mode_chg_unexpected", {31'd0, io_mode_chg}, 32'd0);
        else check("mode_on_chg", {30'd0, io_dpi_mode, io_spi_mode}, {30'd0, exp_mode_q.pop_front()});
      end
    end
  end

  task automatic sck_pulse(input logic [3:0] d);
    @(posedge clock); #1;
    io_dq  = d;
    io_sck = 1'b0;
    repeat (2) @(posedge clock);
    #1 io_sck = 1'b1;
    repeat (2) @(posedge clock);
    #1 io_sck = 1'b0;
  endtask

  // stop: edges of the opcode actually sent; coinc: raise cs_n together with
  // the next SCK rising edge.
  task automatic send_frame(input logic [7:0] op, input int extra, input int stop, input bit coinc);
    int         w, n;
    logic [7:0] t;
    logic [1:0] nm;
    logic [3:0] d;
    w  = (mdl_mode == 2'b00) ? 4 : (mdl_mode == 2'b10) ? 2 : 1;
    n  = 8 / w;
    nm = mdl_mode;
    if (stop >= n) begin
      exp_inst_q.push_back(op);
      if (extra == 0) begin
        nm = model_next(mdl_mode, op);
        if (nm != mdl_mode) exp_mode_q.push_back(nm);
      end
    end
    @(posedge clock); #1;
    io_cs_n = 1'b0;
    io_sck  = 1'b0;
    repeat (2) @(posedge clock);
    t = op;
    for (int i = 0; i < n && i < stop; i++) begin
      if (w == 4)      d = t[7:4];
      else if (w == 2) d = {2'b00, t[7:6]};
      else             d = {3'b000, t[7]};
      t = t << w;
      sck_pulse(d);
    end
    for (int i = 0; i < extra; i++) sck_pulse(4'($urandom_range(0, 15)));
    if (coinc) begin
      repeat (2) @(posedge clock);
      #1 io_sck = 1'b1;
      io_cs_n = 1'b1;
    end else begin
      repeat (2) @(posedge clock);
      #1 io_cs_n = 1'b1;
    end
    repeat (4) @(posedge clock);
    #1 io_sck = 1'b0;
    if (stop >= n) mdl_inst = op;
    mdl_mode = nm;
    check("mode_after_frame", {30'd0, io_dpi_mode, io_spi_mode}, {30'd0, mdl_mode});
    check("inst_after_frame", {24'd0, io_inst}, {24'd0, mdl_inst});
  endtask

  initial begin
    reset   = 1'b1;
    io_cs_n = 1'b1;
    io_sck  = 1'b0;
    io_dq   = 4'h0;
    mdl_mode = 2'b01;
    mdl_inst = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("rst_inst", {24'd0, io_inst}, 32'h00);
    check("rst_vld", {31'd0, io_inst_vld}, 32'd0);
    check("rst_chg", {31'd0, io_mode_chg}, 32'd0);
    check("rst_mode", {30'd0, io_dpi_mode, io_spi_mode}, 32'h1);
    reset = 1'b0;
    repeat (3) @(posedge clock);

    send_frame(8'h35, 0, 8, 1'b0);   // SPI -> QPI
    send_frame(8'hF5, 0, 8, 1'b0);   // QPI -> SPI
    send_frame(8'h35, 8, 8, 1'b0);   // extended: no change
    send_frame(8'hA6, 0, 5, 1'b0);   // aborted: inst retained
    send_frame(8'h35, 0, 7, 1'b1);   // 8th edge lost to cs_n rising
    send_frame(8'h37, 0, 8, 1'b0);   // DPI enter (build dependent)
    send_frame(8'hFF, 0, 8, 1'b0);   // DPI exit / no-op
    send_frame(8'h9F, 0, 8, 1'b0);   // unrelated opcode in SPI
    send_frame(8'h35, 0, 8, 1'b0);   // SPI -> QPI
    send_frame(8'h37, 0, 8, 1'b0);   // no rule from QPI
    send_frame(8'h35, 0, 8, 1'b0);   // QPI stays QPI
    send_frame(8'hF5, 0, 1, 1'b0);   // aborted in QPI

    // Reset in the middle of a QPI frame, acting before any clock edge.
    @(posedge clock); #1;
    io_cs_n = 1'b0;
    repeat (2) @(posedge clock);
    sck_pulse(4'hF);
    #3 reset = 1'b1;
    #1;
    check("async_rst_mode", {30'd0, io_dpi_mode, io_spi_mode}, 32'h1);
    check("async_rst_inst", {24'd0, io_inst}, 32'h00);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    mdl_mode = 2'b01;
    mdl_inst = 8'h00;
    // cs_n still low after release: this frame must be ignored entirely.
    for (int i = 0; i < 8; i++) sck_pulse({3'b000, ((i == 2) || (i == 3) || (i == 5) || (i == 7)) ? 1'b1 : 1'b0});
    repeat (2) @(posedge clock);
    #1 io_cs_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("post_rst_mode", {30'd0, io_dpi_mode, io_spi_mode}, 32'h1);
    check("post_rst_inst", {24'd0, io_inst}, 32'h00);

    send_frame(8'h9F, 0, 8, 1'b0);
    send_frame(8'h35, 0, 8, 1'b0);

    repeat (4) @(posedge clock);
    check("inst_queue_drained", exp_inst_q.size(), 32'd0);
    check("mode_queue_drained", exp_mode_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
